serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: N, default 8, operand width in bits; legal range N >= 2.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request to begin one addition; sampled on the rising edge of clk.
REQ-005 A  input  N  first operand; captured only when start is accepted.
REQ-006 B  input  N  second operand; captured only when start is accepted.
REQ-007 cin  input  1  carry-in to bit 0; captured only when start is accepted.
REQ-008 busy  output  1  high while bits are being processed (SHIFT state).
REQ-009 done  output  1  one-cycle pulse marking that sum and cout are valid.
REQ-010 sum  output  N  result (A + B + cin) mod 2^N.
REQ-011 cout  output  1  carry out of bit N-1.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at a clock edge, the block SHALL capture A, B and cin into operand shift registers and a carry register, clear the bit counter and the sum register, and enter SHIFT.
REQ-014 start SHALL be ignored in SHIFT and DONE, and operand changes outside acceptance SHALL have no effect.
REQ-015 Each SHIFT cycle SHALL produce one full-adder bit from the operand LSBs a0, b0 and the carry register c:
- s = a0^b0^c
- c_next = ((a0^b0)&c) | (a0&b0)
REQ-016 Each SHIFT cycle SHALL:
- shift the operand registers right by one;
- shift the sum register right by one, inserting s at bit N-1;
- load c_next into the carry register;
- increment the counter.
REQ-017 At the edge completing bit N-1 (counter == N-1), the FSM SHALL enter DONE, with sum holding the full result LSB-aligned and cout equal to the final carry.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 Latency: if start is accepted at edge 0, busy SHALL be 1 after edges 0..N-1, done SHALL be 1 after edge N, and IDLE SHALL be re-entered after edge N+1.
REQ-020 A new start SHALL be accepted at the first edge in IDLE, so back-to-back operations issue one N+2-cycle transaction each.
REQ-021 sum and cout SHALL hold their last result through IDLE until the next accepted start clears sum.
REQ-022 sum and cout are intermediate values while busy=1 and SHALL only be treated as valid when done=1 or afterwards in IDLE.
REQ-023 Arithmetic SHALL wrap modulo 2^N, with overflow reported solely on cout; no saturation.
REQ-024 The counter SHALL be clog2(N) bits wide and SHALL never exceed N-1.

Reset
REQ-025 Asserting rst SHALL immediately, without waiting for clk, force:
- state = IDLE;
- busy = 0, done = 0;
- sum = 0, cout = 0;
- the carry register, operand registers and counter = 0.
REQ-026 rst asserted mid-SHIFT SHALL abort the addition with no done pulse; after rst deasserts, the next start SHALL be accepted normally.
REQ-027 start with rst=1 SHALL be ignored.

Verification (N=8)
REQ-028 Scenario 1: A=8'h0F, B=8'h01, cin=0, start pulse -> busy high for 8 cycles, done pulse after edge 8, sum=8'h10, cout=0.
REQ-029 Scenario 2: A=8'hFF, B=8'h01, cin=0 -> sum=8'h00, cout=1 (wrap-around).
REQ-030 Scenario 3: A=8'hFF, B=8'hFF, cin=1 -> sum=8'hFF, cout=1; then A=8'h00, B=8'h00, cin=0 started on the first IDLE edge -> sum=8'h00, cout=0, with the second done exactly 10 cycles after the first.
REQ-031 Scenario 4: start A=8'h12, B=8'h34, then at SHIFT cycle 3 pulse start with A=8'hAA, B=8'h55 -> second request ignored, result sum=8'h46, cout=0, single done.
REQ-032 Scenario 5: start A=8'hAA, B=8'h55, assert rst asynchronously between edges during SHIFT cycle 4 -> busy=0, sum=0, cout=0 before the next edge, no done; after release, A=8'h80, B=8'h80 -> sum=8'h00, cout=1.
REQ-033 Every scenario SHALL compare sum and cout against {cout,sum} = A+B+cin and check done as a single-cycle pulse.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status and the LSB-aligned result out.
interface serial_adder_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  modport master (output start, A, B, cin, input busy, done, sum, cout);
  modport slave  (input start, A, B, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial ripple adder: one full-adder bit per clock, LSB first, with an
// IDLE/SHIFT/DONE controller. Result and carry persist until the next start.
module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           c_q, c_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bit_s;
  logic           bit_c;

  assign bit_s = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_c = ((a_q[0] ^ b_q[0]) & c_q) | (a_q[0] & b_q[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          c_d     = bus.cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sum_d = {bit_s, sum_q[N-1:1]};
        c_d   = bit_c;
        // Counter parks at zero after the last bit so it never passes N-1.
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Carry register doubles as cout: it holds the final carry through IDLE.
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = c_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (N=8): directed scenarios plus
// randomized operations checked against plain integer addition.
module tb_serial_adder_ctrl;
  localparam int N = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   pass_cnt;
  int   fail_cnt;
  int   last_done_cyc;

  serial_adder_ctrl_if #(.N(N)) bus ();

  serial_adder_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction. inj_k >= 0 re-pulses start with other operands
  // while the adder is busy; that request must be ignored.
  task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                    input string tag, input int inj_k);
    logic [N:0] exp_res;
    logic [N:0] at_done;
    int busy_n;
    int done_n;
    int done_k;
    exp_res = (N+1)'(a) + (N+1)'(b) + (N+1)'(ci);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.cin   = ci;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = N'($urandom);
    bus.B     = N'($urandom);
    bus.cin   = 1'($urandom);
    busy_n  = 0;
    done_n  = 0;
    done_k  = -1;
    at_done = '0;
    for (int k = 0; k <= N + 1; k++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        done_k        = k;
        at_done       = {bus.cout, bus.sum};
        last_done_cyc = cyc;
      end
      if (k == inj_k) begin
        bus.start = 1'b1;
        bus.A     = 8'hAA;
        bus.B     = 8'h55;
        bus.cin   = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      if (k < N + 1) begin
        @(posedge clk);
        #1;
      end
    end
    chk({tag, " busy_cycles"}, 32'(busy_n), 32'(N));
    chk({tag, " done_count"}, 32'(done_n), 32'd1);
    chk({tag, " done_latency"}, 32'(done_k), 32'(N));
    chk({tag, " result_at_done"}, 32'(at_done), 32'(exp_res));
    chk({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " idle_hold"}, 32'({bus.cout, bus.sum}), 32'(exp_res));
    $display("txn %s A=%h B=%h cin=%b -> sum=%h cout=%b", tag, a, b, ci, at_done[N-1:0], at_done[N]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d1;
    int seen_done;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic rc;
    int gap;
    total         = 0;
    pass_cnt      = 0;
    fail_cnt      = 0;
    last_done_cyc = 0;

    // Reset with start asserted: must be ignored.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.A     = 8'h5A;
    bus.B     = 8'hA5;
    bus.cin   = 1'b1;
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset sum", 32'(bus.sum), 32'd0);
    chk("reset cout", 32'(bus.cout), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset start_ignored", 32'({bus.busy, bus.done}), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;

    op(8'h0F, 8'h01, 1'b0, "s1", -1);
    op(8'hFF, 8'h01, 1'b0, "s2", -1);
    op(8'hFF, 8'hFF, 1'b1, "s3a", -1);
    d1 = last_done_cyc;
    op(8'h00, 8'h00, 1'b0, "s3b", -1);
    chk("s3 done_spacing", 32'(last_done_cyc - d1), 32'd10);
    op(8'h12, 8'h34, 1'b0, "s4", 3);

    // Scenario 5: asynchronous reset mid-SHIFT aborts without a done pulse.
    seen_done = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 8'hAA;
    bus.B     = 8'h55;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.done) seen_done++;
      @(posedge clk);
      #1;
    end
    chk("s5 busy_before_rst", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("s5 rst_busy", 32'(bus.busy), 32'd0);
    chk("s5 rst_sum", 32'(bus.sum), 32'd0);
    chk("s5 rst_cout", 32'(bus.cout), 32'd0);
    chk("s5 rst_done", 32'(bus.done), 32'd0);
    bus.start = 1'b1;
    bus.A     = 8'h33;
    bus.B     = 8'h44;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen_done++;
    end
    chk("s5 no_done_or_busy", 32'(seen_done), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    op(8'h80, 8'h80, 1'b0, "s5", -1);

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 16; i++) begin
      ra  = N'($urandom);
      rb  = N'($urandom);
      rc  = 1'($urandom);
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(posedge clk);
      op(ra, rb, rc, $sformatf("rnd%0d", i), (i % 3 == 0) ? int'($urandom_range(0, N - 1)) : -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
